alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//  Multi-cycle controller that owns the 8-bit ALU's operand/opcode/status inputs and sequences it.
//  Two command types: a single ALU op (one ALU cycle), and an 8x8 multiply (low 8 bits)
//  built from repeated ALU ADD steps (double-and-add).
//  Sits between the instruction decode stage (request side) and the combinational ALU.
//  Holds the architectural status register across commands.
// PARAMETERS
//  MUL_BITS      8      multiplier bits processed per MUL, MSB first (1..8)
//  STATUS_RESET  8'h00  reset value of the status register
// PORTS
//  clk         in   1  rising-edge clock
//  rst_n       in   1  asynchronous active-low reset
//  req_valid   in   1  command request
//  req_ready   out  1  high in IDLE only; a command is accepted when valid&ready are both high at a clk edge
//  req_cmd     in   1  0 = single ALU op, 1 = MUL
//  req_aop     in   5  ALU opcode for single op; ignored for MUL
//  req_a       in   8  operand A (ALU x / multiplicand)
//  req_b       in   8  operand B (ALU y / multiplier)
//  rsp_valid   out  1  result available, held until consumed
//  rsp_ready   in   1  consumer accepts result
//  rsp_data    out  8  result
//  rsp_status  out  8  status register (bit1 = zero flag, bit0 = equal flag)
//  busy        out  1  high in every state except IDLE
//  alu_aop     out  5  ALU opcode; encodings: RETX=5'b00000, ADD=5'b00010
//  alu_x       out  8  ALU operand x
//  alu_y       out  8  ALU operand y
//  alu_s       out  8  ALU status in; always equals the status register
//  alu_o       in   8  ALU result, sampled in the same cycle
//  alu_os      in   8  ALU status out, sampled in the same cycle
// BEHAVIOUR
//  Reset: state=IDLE; acc, a_q, b_q, aop_q, cnt = 0; status = STATUS_RESET.
//   Outputs: req_ready=1, rsp_valid=0, busy=0, rsp_data=0, alu_aop=RETX, alu_x=alu_y=0.
//  FSM states: IDLE, SINGLE, DBL, ADDA, DONE. Registered state; ALU outputs decoded from state.
//  IDLE: ALU driven with RETX, x=0, y=0.
//   On accept: latch a, b and aop; acc<=0; cnt<=MUL_BITS-1. Next state SINGLE if cmd=0, else DBL.
//  SINGLE: alu_aop=aop_q, x=a_q, y=b_q. acc<=alu_o; status<=alu_os. Next state DONE.
//  DBL: alu_aop=ADD, x=acc, y=acc. acc<=alu_o; status<=alu_os. Next state:
//   ADDA if b_q[cnt]=1; else DONE if cnt==0; else DBL with cnt-1.
//  ADDA: alu_aop=ADD, x=acc, y=a_q. acc<=alu_o; status<=alu_os. Next state:
//   DONE if cnt==0; else DBL with cnt-1.
//  DONE: rsp_valid=1; rsp_data=acc, held stable.
//   On rsp_valid&rsp_ready: go to IDLE; the same edge cannot accept a new command.
//  Latency, counted from the accept edge to the first rsp_valid cycle:
//   single op = 2 cycles; MUL = MUL_BITS + popcount(b[MUL_BITS-1:0]) + 1 cycles.
//  Arithmetic: all adds wrap mod 256; no carry is kept. Final zero flag reflects the last ADD step.
//  Status persists between commands; bits not written by the ALU pass through unchanged.
//  req_valid while busy: ignored (req_ready=0); the request must be held by the requester.
//  Request inputs changing after accept: no effect (all operands are latched).
//  rsp_ready low: remain in DONE indefinitely.
//  rst_n low at any point, including mid-MUL: immediate return to the reset values;
//   any in-flight command is dropped with no response.
// TESTING
//  1 single ADD: aop=5'b00010, a=8'h05, b=8'h03
//    -> rsp_data=8'h08, status[1]=0, rsp_valid 2 cycles after accept.
//  2 MUL a=8'd13, b=8'd11
//    -> rsp_data=8'h8F, rsp_valid 12 cycles after accept, 3 ADDA visits.
//  3 MUL a=8'd16, b=8'd16
//    -> rsp_data=8'h00 (wrap), status[1]=1.
//  4 MUL a=8'hFF, b=8'h00
//    -> rsp_data=8'h00, ADDA never entered, rsp_valid 9 cycles after accept.
//  5 backpressure: hold rsp_ready=0 for 5 cycles while req_valid=1
//    -> req_ready=0 and rsp_data stable throughout; the new command is accepted only after return to IDLE.
//  6 drop rst_n mid-MUL with no clock edge
//    -> busy=0, rsp_valid=0, status=STATUS_RESET immediately; first command after release runs correctly.

Source files
------------

// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake bundle between decode and the ALU sequencer.
// master = instruction decode side, slave = sequencer.
interface alu_mul_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_cmd;
    logic [4:0] req_aop;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] rsp_status;

    modport master (
        output req_valid, req_cmd, req_aop, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_status
    );

    modport slave (
        input  req_valid, req_cmd, req_aop, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Sequences the combinational 8-bit ALU for single ops and for 8x8 (low byte)
// multiplies built from double-and-add steps; owns the architectural status register.
module alu_mul_sequencer #(
    parameter int unsigned MUL_BITS     = 8,
    parameter logic [7:0]  STATUS_RESET = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_mul_sequencer_if.slave   bus,
    output logic                 busy,
    output logic [4:0]           alu_aop,
    output logic [7:0]           alu_x,
    output logic [7:0]           alu_y,
    output logic [7:0]           alu_s,
    input  logic [7:0]           alu_o,
    input  logic [7:0]           alu_os
);
    localparam int unsigned DW    = 8;
    localparam int unsigned AOPW  = 5;
    localparam int unsigned CNT_W = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;
    localparam logic [AOPW-1:0] AOP_RETX = 5'b00000;
    localparam logic [AOPW-1:0] AOP_ADD  = 5'b00010;

    typedef enum logic [2:0] {IDLE, SINGLE, DBL, ADDA, DONE} state_t;

    state_t             state, state_nxt;
    logic [DW-1:0]      acc, acc_nxt;
    logic [DW-1:0]      a_q, a_nxt;
    logic [DW-1:0]      b_q, b_nxt;
    logic [AOPW-1:0]    aop_q, aop_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]      status, status_nxt;

    logic               ready_q, valid_q, busy_q;
    logic [AOPW-1:0]    alu_aop_nxt;
    logic [DW-1:0]      alu_x_nxt, alu_y_nxt;

    // Next-state / datapath; ALU drive is decoded from the next state so it is registered.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        a_nxt      = a_q;
        b_nxt      = b_q;
        aop_nxt    = aop_q;
        cnt_nxt    = cnt;
        status_nxt = status;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    a_nxt     = bus.req_a;
                    b_nxt     = bus.req_b;
                    aop_nxt   = bus.req_aop;
                    acc_nxt   = '0;
                    cnt_nxt   = CNT_W'(MUL_BITS - 1);
                    state_nxt = bus.req_cmd ? DBL : SINGLE;
                end
            end
            SINGLE: begin
                acc_nxt    = alu_o;
                status_nxt = alu_os;
                state_nxt  = DONE;
            end
            DBL: begin
                acc_nxt    = alu_o;
                status_nxt = alu_os;
                if (b_q[cnt]) begin
                    state_nxt = ADDA;
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                    state_nxt = DBL;
                end
            end
            ADDA: begin
                acc_nxt    = alu_o;
                status_nxt = alu_os;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                    state_nxt = DBL;
                end
            end
            DONE: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        alu_aop_nxt = AOP_RETX;
        alu_x_nxt   = '0;
        alu_y_nxt   = '0;
        case (state_nxt)
            SINGLE: begin
                alu_aop_nxt = aop_nxt;
                alu_x_nxt   = a_nxt;
                alu_y_nxt   = b_nxt;
            end
            DBL: begin
                alu_aop_nxt = AOP_ADD;
                alu_x_nxt   = acc_nxt;
                alu_y_nxt   = acc_nxt;
            end
            ADDA: begin
                alu_aop_nxt = AOP_ADD;
                alu_x_nxt   = acc_nxt;
                alu_y_nxt   = a_nxt;
            end
            default: ;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            aop_q   <= '0;
            cnt     <= '0;
            status  <= STATUS_RESET;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            alu_aop <= AOP_RETX;
            alu_x   <= '0;
            alu_y   <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            aop_q   <= aop_nxt;
            cnt     <= cnt_nxt;
            status  <= status_nxt;
            ready_q <= (state_nxt == IDLE);
            valid_q <= (state_nxt == DONE);
            busy_q  <= (state_nxt != IDLE);
            alu_aop <= alu_aop_nxt;
            alu_x   <= alu_x_nxt;
            alu_y   <= alu_y_nxt;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = valid_q;
    assign bus.rsp_data   = acc;
    assign bus.rsp_status = status;
    assign busy           = busy_q;
    assign alu_s          = status;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU, scoreboard of expected responses,
// one task per scenario.
module tb_alu_mul_sequencer;
    localparam int unsigned MUL_BITS = 8;
    localparam logic [4:0] AOP_RETX = 5'b00000;
    localparam logic [4:0] AOP_ADD  = 5'b00010;
    localparam logic [4:0] AOP_XOR  = 5'b00100;
    localparam int TIMEOUT = 200;

    typedef struct {
        logic [7:0] data;
        logic       z;
        int         lat;
        int         adda;
        bit         chk_adda;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_mul_sequencer_if bus();
    logic       busy;
    logic [4:0] alu_aop;
    logic [7:0] alu_x, alu_y, alu_s, alu_o, alu_os;

    alu_mul_sequencer #(.MUL_BITS(MUL_BITS), .STATUS_RESET(8'h00)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .alu_aop(alu_aop),
        .alu_x  (alu_x),
        .alu_y  (alu_y),
        .alu_s  (alu_s),
        .alu_o  (alu_o),
        .alu_os (alu_os)
    );

    // Behavioural ALU: ADD, XOR, anything else returns x; status bit1 zero, bit0 equal.
    always_comb begin
        case (alu_aop)
            AOP_ADD: alu_o = alu_x + alu_y;
            AOP_XOR: alu_o = alu_x ^ alu_y;
            default: alu_o = alu_x;
        endcase
        alu_os = {alu_s[7:2], (alu_o == 8'h00), (alu_x == alu_y)};
    end

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic exp_t make_exp(input bit cmd, input logic [4:0] aop,
                                      input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [15:0] prod;
        if (cmd) begin
            prod       = 16'(a) * 16'(b);
            e.data     = prod[7:0];
            e.adda     = $countones(b);
            e.lat      = MUL_BITS + e.adda + 1;
            e.chk_adda = 1'b1;
        end else begin
            case (aop)
                AOP_ADD: e.data = a + b;
                AOP_XOR: e.data = a ^ b;
                default: e.data = a;
            endcase
            e.adda     = 0;
            e.lat      = 2;
            e.chk_adda = 1'b0;
        end
        e.z = (e.data == 8'h00);
        return e;
    endfunction

    // Drive a command, push its expectation, wait for the accept edge, then scramble inputs.
    task automatic issue(input bit cmd, input logic [4:0] aop, input logic [7:0] a, input logic [7:0] b);
        int guard;
        @(negedge clk);
        sb.push_back(make_exp(cmd, aop, a, b));
        bus.req_cmd   = cmd;
        bus.req_aop   = aop;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= TIMEOUT) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = ~a;
        bus.req_b     = ~b;
        bus.req_aop   = ~aop;
        bus.req_cmd   = ~cmd;
    endtask

    // Wait for the response following an accept edge and compare it with the scoreboard head.
    task automatic collect(input string name, input bit consume);
        exp_t e;
        int lat, adda;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        lat  = 0;
        adda = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.rsp_valid && alu_aop == AOP_ADD && alu_x != alu_y) adda++;
        end while (!bus.rsp_valid && lat < TIMEOUT);
        n_checks++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rsp_timeout: rsp_valid=%0b required 1", name, bus.rsp_valid);
        end
        n_checks++;
        if (lat != e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
        end
        n_checks++;
        if (bus.rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL %s data: got %h required %h", name, bus.rsp_data, e.data);
        end
        n_checks++;
        if (bus.rsp_status[1] !== e.z) begin
            n_fail++;
            $display("FAIL %s zero_flag: got %b required %b", name, bus.rsp_status[1], e.z);
        end
        if (e.chk_adda) begin
            n_checks++;
            if (adda != e.adda) begin
                n_fail++;
                $display("FAIL %s adda_visits: got %0d required %0d", name, adda, e.adda);
            end
        end
        if (consume) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_hs: ready/valid/busy=%b required 100", {bus.req_ready, bus.rsp_valid, busy});
        end
        n_checks++;
        if ({bus.rsp_data, bus.rsp_status, alu_s} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_regs: data/status/alu_s=%h required 000000", {bus.rsp_data, bus.rsp_status, alu_s});
        end
        n_checks++;
        if ({alu_aop, alu_x, alu_y} !== {AOP_RETX, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_alu: aop/x/y=%h required %h", {alu_aop, alu_x, alu_y}, {AOP_RETX, 16'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        issue(1'b0, AOP_ADD, 8'h05, 8'h03);
        collect("single_add", 1'b1);
        issue(1'b0, AOP_XOR, 8'h5A, 8'h5A);
        collect("single_xor_zero", 1'b1);
        issue(1'b0, AOP_XOR, 8'h5A, 8'h0F);
        collect("single_xor", 1'b1);
    endtask

    task automatic test_mul();
        issue(1'b1, 5'h1F, 8'd13, 8'd11);
        collect("mul_13x11", 1'b1);
        issue(1'b1, AOP_RETX, 8'd16, 8'd16);
        collect("mul_16x16_wrap", 1'b1);
        @(negedge clk);
        n_checks++;
        if ({alu_s[1], bus.rsp_status[1], busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL status_persist: alu_s1/status1/busy=%b required 110", {alu_s[1], bus.rsp_status[1], busy});
        end
        issue(1'b1, AOP_ADD, 8'hFF, 8'h00);
        collect("mul_ff_x_00", 1'b1);
        issue(1'b1, AOP_ADD, 8'hFF, 8'hFF);
        collect("mul_ff_x_ff", 1'b1);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, AOP_ADD, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            collect("mul_rand", 1'b1);
        end
    endtask

    task automatic test_backpressure();
        issue(1'b0, AOP_ADD, 8'h21, 8'h10);
        collect("bp_first", 1'b0);
        sb.push_back(make_exp(1'b1, AOP_ADD, 8'd7, 8'd6));
        bus.req_cmd   = 1'b1;
        bus.req_aop   = AOP_ADD;
        bus.req_a     = 8'd7;
        bus.req_b     = 8'd6;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.req_ready, bus.rsp_valid, bus.rsp_data} !== {2'b01, 8'h31}) begin
                n_fail++;
                $display("FAIL bp_hold: ready/valid/data=%h required %h", {bus.req_ready, bus.rsp_valid, bus.rsp_data}, {2'b01, 8'h31});
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, busy, bus.rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_idle_gap: ready/busy/valid=%b required 100", {bus.req_ready, busy, bus.rsp_valid});
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = 8'hAA;
        bus.req_b     = 8'hFF;
        collect("bp_second", 1'b1);
    endtask

    task automatic test_reset_mid_mul();
        issue(1'b1, AOP_ADD, 8'd13, 8'd11);
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || bus.rsp_status === 8'h00) begin
            n_fail++;
            $display("FAIL mid_mul_busy: busy=%b status=%h required busy 1 and status nonzero", busy, bus.rsp_status);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, bus.rsp_valid, bus.req_ready, bus.rsp_status, alu_aop} !== {3'b001, 8'h00, AOP_RETX}) begin
            n_fail++;
            $display("FAIL async_reset: busy/valid/ready/status/aop=%h required %h",
                     {busy, bus.rsp_valid, bus.req_ready, bus.rsp_status, alu_aop}, {3'b001, 8'h00, AOP_RETX});
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, AOP_ADD, 8'd9, 8'd5);
        collect("after_reset_mul", 1'b1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_cmd   = 1'b0;
        bus.req_aop   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
